display_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 scan generator. It derives a pixel strobe from the system clock using a programmable divider, so no derived clock domain exists, and it runs the horizontal and vertical scan counters. It decodes sync, blanking and visible position in registered form, and emits line/frame start pulses and a frame counter. It feeds the pixel pipeline and the VGA output pins; every timing value is a parameter.

---
 rtl/display_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_display_timing_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/display_timing_gen.sv
// Pixel/line/frame scan timing generator running on the system clock with a pixel-rate strobe.
// Every decoded output is registered from the next counter values, so it lines up with h_pos/v_pos.
module display_timing_gen #(
    parameter int HCOUNT_WIDTH = 10,
    parameter int VCOUNT_WIDTH = 10,
    parameter int FRAME_WIDTH  = 8,
    parameter int CLK_DIV      = 2,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int H_VISIBLE    = 640,
    parameter int H_FRONT      = 16,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 10,
    parameter bit H_SYNC_POL   = 1'b0,
    parameter bit V_SYNC_POL   = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    output logic                    pix_en,
    output logic [HCOUNT_WIDTH-1:0] h_pos,
    output logic [VCOUNT_WIDTH-1:0] v_pos,
    output logic                    h_sync,
    output logic                    v_sync,
    output logic                    h_blank,
    output logic                    v_blank,
    output logic                    blank,
    output logic [HCOUNT_WIDTH-1:0] h_visible_pos,
    output logic [VCOUNT_WIDTH-1:0] v_visible_pos,
    output logic                    line_start,
    output logic                    frame_start,
    output logic [FRAME_WIDTH-1:0]  frame_count
);

    localparam int H_VIS_START   = H_SYNC + H_BACK;
    localparam int H_FRONT_START = H_VIS_START + H_VISIBLE;
    localparam int H_TOTAL       = H_FRONT_START + H_FRONT;
    localparam int V_VIS_START   = V_SYNC + V_BACK;
    localparam int V_FRONT_START = V_VIS_START + V_VISIBLE;
    localparam int V_TOTAL       = V_FRONT_START + V_FRONT;
    localparam int DIV_W         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HCOUNT_WIDTH-1:0] H_LAST   = HCOUNT_WIDTH'(H_TOTAL - 1);
    localparam logic [VCOUNT_WIDTH-1:0] V_LAST   = VCOUNT_WIDTH'(V_TOTAL - 1);
    localparam logic [HCOUNT_WIDTH-1:0] H_VS     = HCOUNT_WIDTH'(H_VIS_START);
    localparam logic [VCOUNT_WIDTH-1:0] V_VS     = VCOUNT_WIDTH'(V_VIS_START);
    // One extra bit so a boundary equal to 2^WIDTH still compares correctly.
    localparam logic [HCOUNT_WIDTH:0]   H_SYNC_X = (HCOUNT_WIDTH+1)'(H_SYNC);
    localparam logic [HCOUNT_WIDTH:0]   H_VS_X   = (HCOUNT_WIDTH+1)'(H_VIS_START);
    localparam logic [HCOUNT_WIDTH:0]   H_FS_X   = (HCOUNT_WIDTH+1)'(H_FRONT_START);
    localparam logic [VCOUNT_WIDTH:0]   V_SYNC_X = (VCOUNT_WIDTH+1)'(V_SYNC);
    localparam logic [VCOUNT_WIDTH:0]   V_VS_X   = (VCOUNT_WIDTH+1)'(V_VIS_START);
    localparam logic [VCOUNT_WIDTH:0]   V_FS_X   = (VCOUNT_WIDTH+1)'(V_FRONT_START);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("CLK_DIV must be at least 1");
        end
        if (H_TOTAL > (1 << HCOUNT_WIDTH)) begin : g_bad_h
            $error("H_TOTAL does not fit in HCOUNT_WIDTH");
        end
        if (V_TOTAL > (1 << VCOUNT_WIDTH)) begin : g_bad_v
            $error("V_TOTAL does not fit in VCOUNT_WIDTH");
        end
    endgenerate

    function automatic logic h_sync_of(input logic [HCOUNT_WIDTH-1:0] p);
        return ({1'b0, p} < H_SYNC_X) ? H_SYNC_POL : ~H_SYNC_POL;
    endfunction

    function automatic logic v_sync_of(input logic [VCOUNT_WIDTH-1:0] p);
        return ({1'b0, p} < V_SYNC_X) ? V_SYNC_POL : ~V_SYNC_POL;
    endfunction

    function automatic logic h_blank_of(input logic [HCOUNT_WIDTH-1:0] p);
        return ({1'b0, p} < H_VS_X) || ({1'b0, p} >= H_FS_X);
    endfunction

    function automatic logic v_blank_of(input logic [VCOUNT_WIDTH-1:0] p);
        return ({1'b0, p} < V_VS_X) || ({1'b0, p} >= V_FS_X);
    endfunction

    logic [DIV_W-1:0]        r_div_cnt;
    logic [HCOUNT_WIDTH-1:0] r_h_pos;
    logic [VCOUNT_WIDTH-1:0] r_v_pos;
    logic [FRAME_WIDTH-1:0]  r_frame_count;
    logic                    r_pix_en, r_line_start, r_frame_start;
    logic                    r_h_sync, r_v_sync, r_h_blank, r_v_blank, r_blank;
    logic [HCOUNT_WIDTH-1:0] r_h_vis;
    logic [VCOUNT_WIDTH-1:0] r_v_vis;

    logic                    w_tick, w_h_last, w_v_last;
    logic [DIV_W-1:0]        w_div_next;
    logic [HCOUNT_WIDTH-1:0] w_h_next;
    logic [VCOUNT_WIDTH-1:0] w_v_next;
    logic [FRAME_WIDTH-1:0]  w_frame_next;

    assign w_tick   = enable && (r_div_cnt == DIV_LAST);
    assign w_h_last = (r_h_pos == H_LAST);
    assign w_v_last = (r_v_pos == V_LAST);

    always_comb begin
        w_div_next   = r_div_cnt;
        w_h_next     = r_h_pos;
        w_v_next     = r_v_pos;
        w_frame_next = r_frame_count;
        if (enable) begin
            w_div_next = w_tick ? '0 : r_div_cnt + 1'b1;
        end
        if (w_tick) begin
            if (w_h_last) begin
                w_h_next = '0;
                if (w_v_last) begin
                    w_v_next     = '0;
                    w_frame_next = r_frame_count + 1'b1;
                end else begin
                    w_v_next = r_v_pos + 1'b1;
                end
            end else begin
                w_h_next = r_h_pos + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt     <= '0;
            r_h_pos       <= '0;
            r_v_pos       <= '0;
            r_frame_count <= '0;
            r_pix_en      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_h_sync      <= h_sync_of('0);
            r_v_sync      <= v_sync_of('0);
            r_h_blank     <= h_blank_of('0);
            r_v_blank     <= v_blank_of('0);
            r_blank       <= h_blank_of('0) | v_blank_of('0);
            r_h_vis       <= '0 - H_VS;
            r_v_vis       <= '0 - V_VS;
        end else begin
            r_div_cnt     <= w_div_next;
            r_h_pos       <= w_h_next;
            r_v_pos       <= w_v_next;
            r_frame_count <= w_frame_next;
            r_pix_en      <= w_tick;
            r_line_start  <= w_tick & w_h_last;
            r_frame_start <= w_tick & w_h_last & w_v_last;
            r_h_sync      <= h_sync_of(w_h_next);
            r_v_sync      <= v_sync_of(w_v_next);
            r_h_blank     <= h_blank_of(w_h_next);
            r_v_blank     <= v_blank_of(w_v_next);
            r_blank       <= h_blank_of(w_h_next) | v_blank_of(w_v_next);
            r_h_vis       <= w_h_next - H_VS;
            r_v_vis       <= w_v_next - V_VS;
        end
    end

    assign pix_en        = r_pix_en;
    assign h_pos         = r_h_pos;
    assign v_pos         = r_v_pos;
    assign h_sync        = r_h_sync;
    assign v_sync        = r_v_sync;
    assign h_blank       = r_h_blank;
    assign v_blank       = r_v_blank;
    assign blank         = r_blank;
    assign h_visible_pos = r_h_vis;
    assign v_visible_pos = r_v_vis;
    assign line_start    = r_line_start;
    assign frame_start   = r_frame_start;
    assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: three instances (small timing, defaults, CLK_DIV=1 with
// positive h_sync) compared every cycle against a tick-count arithmetic reference model.
module tb_display_timing_gen;

    localparam int NI = 3;
    localparam int P_DIV  [NI] = '{3, 2, 1};
    localparam int P_HS   [NI] = '{4, 96, 96};
    localparam int P_HB   [NI] = '{3, 48, 48};
    localparam int P_HV   [NI] = '{10, 640, 640};
    localparam int P_HF   [NI] = '{2, 16, 16};
    localparam int P_VS   [NI] = '{2, 2, 2};
    localparam int P_VB   [NI] = '{3, 33, 33};
    localparam int P_VV   [NI] = '{5, 480, 480};
    localparam int P_VF   [NI] = '{2, 10, 10};
    localparam int P_HPOL [NI] = '{0, 0, 1};
    localparam int P_VPOL [NI] = '{1, 0, 0};
    localparam int N_CYCLES = 6000;

    logic       clk = 1'b0;
    logic       rst    [NI];
    logic       en     [NI];
    logic       pix_en [NI];
    logic [9:0] h_pos  [NI];
    logic [9:0] v_pos  [NI];
    logic       h_sync [NI];
    logic       v_sync [NI];
    logic       h_blank[NI];
    logic       v_blank[NI];
    logic       blank  [NI];
    logic [9:0] h_vis  [NI];
    logic [9:0] v_vis  [NI];
    logic       line_s [NI];
    logic       frame_s[NI];
    logic [7:0] frame_c[NI];

    int n_checks = 0;
    int n_errors = 0;

    // Clock / reset
    always #5 clk = ~clk;

    display_timing_gen #(
        .CLK_DIV(3), .H_SYNC(4), .H_BACK(3), .H_VISIBLE(10), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(3), .V_VISIBLE(5), .V_FRONT(2),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1)
    ) dut_small (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .pix_en(pix_en[0]),
        .h_pos(h_pos[0]), .v_pos(v_pos[0]), .h_sync(h_sync[0]), .v_sync(v_sync[0]),
        .h_blank(h_blank[0]), .v_blank(v_blank[0]), .blank(blank[0]),
        .h_visible_pos(h_vis[0]), .v_visible_pos(v_vis[0]),
        .line_start(line_s[0]), .frame_start(frame_s[0]), .frame_count(frame_c[0])
    );

    display_timing_gen dut_default (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .pix_en(pix_en[1]),
        .h_pos(h_pos[1]), .v_pos(v_pos[1]), .h_sync(h_sync[1]), .v_sync(v_sync[1]),
        .h_blank(h_blank[1]), .v_blank(v_blank[1]), .blank(blank[1]),
        .h_visible_pos(h_vis[1]), .v_visible_pos(v_vis[1]),
        .line_start(line_s[1]), .frame_start(frame_s[1]), .frame_count(frame_c[1])
    );

    display_timing_gen #(
        .CLK_DIV(1), .H_SYNC_POL(1'b1)
    ) dut_div1 (
        .clk(clk), .reset(rst[2]), .enable(en[2]), .pix_en(pix_en[2]),
        .h_pos(h_pos[2]), .v_pos(v_pos[2]), .h_sync(h_sync[2]), .v_sync(v_sync[2]),
        .h_blank(h_blank[2]), .v_blank(v_blank[2]), .blank(blank[2]),
        .h_visible_pos(h_vis[2]), .v_visible_pos(v_vis[2]),
        .line_start(line_s[2]), .frame_start(frame_s[2]), .frame_count(frame_c[2])
    );

    // Reference model: enabled clocks since reset -> pixel ticks -> scan position.
    longint en_cnt [NI] = '{0, 0, 0};
    bit     last_en[NI] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst[i]) begin
                en_cnt[i]  = 0;
                last_en[i] = 0;
            end else if (en[i]) begin
                en_cnt[i]  = en_cnt[i] + 1;
                last_en[i] = 1;
            end else begin
                last_en[i] = 0;
            end
        end
    end

    function automatic longint model_h(input int i);
        longint ht = P_HS[i] + P_HB[i] + P_HV[i] + P_HF[i];
        return (en_cnt[i] / P_DIV[i]) % ht;
    endfunction

    // Scoreboard check
    task automatic check(input int inst, input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL inst%0d %s: got %0d expected %0d (t=%0t)", inst, tag, obs, exp, $time);
        end
    endtask

    task automatic check_inst(input int i);
        longint ht, vt, n, line, h, v, f, hvs, hfs, vvs, vfs;
        bit pe, hb, vb, hs_act, vs_act;
        ht   = P_HS[i] + P_HB[i] + P_HV[i] + P_HF[i];
        vt   = P_VS[i] + P_VB[i] + P_VV[i] + P_VF[i];
        n    = en_cnt[i] / P_DIV[i];
        h    = n % ht;
        line = n / ht;
        v    = line % vt;
        f    = (line / vt) % 256;
        pe   = last_en[i] && (en_cnt[i] % P_DIV[i] == 0);
        hvs  = P_HS[i] + P_HB[i];
        hfs  = hvs + P_HV[i];
        vvs  = P_VS[i] + P_VB[i];
        vfs  = vvs + P_VV[i];
        hb   = (h < hvs) || (h >= hfs);
        vb   = (v < vvs) || (v >= vfs);
        hs_act = (h < P_HS[i]);
        vs_act = (v < P_VS[i]);
        check(i, "pix_en", longint'(pix_en[i]), longint'(pe));
        check(i, "h_pos", longint'(h_pos[i]), h);
        check(i, "v_pos", longint'(v_pos[i]), v);
        check(i, "h_sync", longint'(h_sync[i]), hs_act ? P_HPOL[i] : 1 - P_HPOL[i]);
        check(i, "v_sync", longint'(v_sync[i]), vs_act ? P_VPOL[i] : 1 - P_VPOL[i]);
        check(i, "h_blank", longint'(h_blank[i]), longint'(hb));
        check(i, "v_blank", longint'(v_blank[i]), longint'(vb));
        check(i, "blank", longint'(blank[i]), longint'(hb | vb));
        check(i, "h_visible_pos", longint'(h_vis[i]), ((h - hvs) % 1024 + 1024) % 1024);
        check(i, "v_visible_pos", longint'(v_vis[i]), ((v - vvs) % 1024 + 1024) % 1024);
        check(i, "line_start", longint'(line_s[i]), longint'(pe && h == 0));
        check(i, "frame_start", longint'(frame_s[i]), longint'(pe && h == 0 && v == 0));
        check(i, "frame_count", longint'(frame_c[i]), f);
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) check_inst(i);
    endtask

    int  pause_left = 0;
    bit  pause_done = 0;

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1;
            en[i]  = 1'b0;
        end
        step();
        step();
        check_all();
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b0;
            en[i]  = 1'b1;
        end
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            step();
            check_all();
            // small timing: random stalls and rare mid-frame resets
            en[0]  = ($urandom_range(0, 7) != 0);
            rst[0] = ($urandom_range(0, 799) == 0);
            // defaults: one 10-clock freeze at h_pos 300, one reset with enable held high
            if (!pause_done && model_h(1) == 300) begin
                pause_done = 1;
                pause_left = 10;
            end
            en[1]  = (pause_left == 0);
            if (pause_left > 0) pause_left--;
            rst[1] = (cyc == 4500);
            // CLK_DIV=1: random stalls and rare resets
            en[2]  = ($urandom_range(0, 3) != 0);
            rst[2] = ($urandom_range(0, 1499) == 0);
        end
        step();
        check_all();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
